// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg: shared types and constants for the Wishbone data-side RAM responder.
package zap_wb_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } wb_state_e;

    // A Wishbone request as latched at acceptance
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    // Cycle-type identifiers, held back for a burst-capable revision
    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_CONST   = 3'b001;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    // Burst-type extensions, held back for a burst-capable revision
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

    // Window test done in 33 bits so a window ending at 4 GiB does not wrap
    function automatic logic wb_in_window(input logic [31:0] adr,
                                          input logic [32:0] lo,
                                          input logic [32:0] hi);
        return ({1'b0, adr} >= lo) && ({1'b0, adr} < hi);
    endfunction

endpackage

// File: rtl/zap_wb_bytelane_ram.sv
// zap_wb_bytelane_ram: single-port DEPTH_WORDS x 32 RAM with per-byte write
// enables and a registered read port that holds its value between reads.
module zap_wb_bytelane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_rd,
    input  logic [3:0]    i_wbe,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes; storage contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_wbe[b]) begin
                mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Registered read data, updated only on a read so writes/errors leave it alone
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata <= '0;
        end else if (i_rd) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/zap_wb_ram_responder.sv
// zap_wb_ram_responder: Wishbone B3 classic data-side slave backed by a
// byte-lane-writable word RAM, with programmable wait states and an error
// acknowledge for addresses outside the RAM window.
module zap_wb_ram_responder
    import zap_wb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [31:0] o_wb_dat
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = WIN_LO + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_e     state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    wb_req_t       req_q, req_live, req_cur;
    logic          req_go, in_win;
    logic          ack_q, err_q;
    logic          ram_access, ram_rd;
    logic [3:0]    ram_wbe;
    logic [31:0]   adr_offset;
    logic [AW-1:0] ram_idx;
    logic          unused_offset_bits;

    assign req_live = '{adr: i_wb_adr, dat: i_wb_dat, sel: i_wb_sel, we: i_wb_we};
    assign req_go   = i_wb_cyc & i_wb_stb;
    assign in_win   = wb_in_window(i_wb_adr, WIN_LO, WIN_HI);

    // With no wait states the RAM is accessed on the accepting edge itself,
    // before the request has been latched, so take it straight off the bus.
    assign req_cur    = (state_q == ST_IDLE) ? req_live : req_q;
    assign adr_offset = req_cur.adr - BASE_ADDR;
    assign ram_idx    = adr_offset[AW+1:2];

    // The RAM is touched only on the edge that enters RESP
    assign ram_access = (state_d == ST_RESP);
    assign ram_rd     = ram_access & ~req_cur.we;
    assign ram_wbe    = (ram_access & req_cur.we) ? req_cur.sel : 4'b0000;

    assign unused_offset_bits = ^{adr_offset[31:AW+2], adr_offset[1:0]};

    // Next-state and wait-counter logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_go) begin
                    if (!in_win) begin
                        state_d = ST_ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    // Initiator abandoned the cycle: drop the request silently
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, request latch and registered acknowledges
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            req_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if ((state_q == ST_IDLE) && req_go) begin
                req_q <= req_live;
            end
            ack_q <= (state_d == ST_RESP);
            err_q <= (state_d == ST_ERR);
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;

    zap_wb_bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_rd      (ram_rd),
        .i_wbe     (ram_wbe),
        .i_addr    (ram_idx),
        .i_wdata   (req_cur.dat),
        .o_rdata   (o_wb_dat)
    );

endmodule

// File: tb/tb_zap_wb_ram_responder.sv
// tb_zap_wb_ram_responder: scoreboard bench for three responder configurations
// (wait states 3/0/1, offset and zero-based windows).
`timescale 1ns/1ps
module tb_zap_wb_ram_responder;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst_n, cyc, stb, we, ack, err;
    logic [N-1:0][31:0] adr, wdat, rdat;
    logic [N-1:0][3:0]  sel;

    zap_wb_ram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
        .i_wb_adr(adr[0]), .i_wb_dat(wdat[0]), .i_wb_sel(sel[0]),
        .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_dat(rdat[0]));
    zap_wb_ram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
        .i_wb_adr(adr[1]), .i_wb_dat(wdat[1]), .i_wb_sel(sel[1]),
        .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_dat(rdat[1]));
    zap_wb_ram_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_dut2 (
        .i_clk(clk), .i_reset_n(rst_n[2]), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
        .i_wb_adr(adr[2]), .i_wb_dat(wdat[2]), .i_wb_sel(sel[2]),
        .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_wb_dat(rdat[2]));

    function automatic int ws_of(input int k);
        case (k) 0: return 3; 1: return 0; default: return 1; endcase
    endfunction
    function automatic longint base_of(input int k);
        return (k == 0) ? 64'h1000 : 64'h0;
    endfunction
    function automatic longint depth_of(input int k);
        case (k) 0: return 1024; 1: return 16; default: return 64; endcase
    endfunction
    function automatic bit in_win_m(input int k, input logic [31:0] a);
        return (longint'(a) >= base_of(k)) && (longint'(a) < base_of(k) + depth_of(k) * 4);
    endfunction

    // Reference model state
    typedef struct { bit is_err; int cyc; logic [31:0] dat; } exp_t;
    exp_t        q0[$], q1[$], q2[$];
    logic [31:0] mem_m [N][1024];
    logic [31:0] last_dat [N];
    int          next_free [N];
    int          resp_cnt [N];
    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void q_push(input int k, input exp_t e);
        case (k) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
    endfunction
    function automatic int q_size(input int k);
        case (k) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
    endfunction
    function automatic exp_t q_pop(input int k);
        case (k) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every ack/err is matched against the oldest expectation
    task automatic mon_step(input int k);
        exp_t e;
        if (ack[k] || err[k]) begin
            resp_cnt[k]++;
            check_eq($sformatf("dut%0d ack_err_exclusive", k), {31'b0, ack[k] & err[k]}, 32'd0);
            if (q_size(k) == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d unexpected_response: got ack=%0b err=%0b, expected none", k, ack[k], err[k]);
            end else begin
                e = q_pop(k);
                check_eq($sformatf("dut%0d resp_kind", k), {30'b0, ack[k], err[k]}, {30'b0, ~e.is_err, e.is_err});
                check_eq($sformatf("dut%0d resp_cycle", k), cyc_cnt, e.cyc);
                check_eq($sformatf("dut%0d resp_dat", k), rdat[k], e.dat);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) mon_step(k);
    end

    // Issue one request (called just after a negedge) and wait for its response.
    // A request launched after edge L is accepted at edge L+1 (or once the
    // responder is back in IDLE); ack follows L+1+WAIT_STATES, err follows L+1.
    task automatic do_req(input int k, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] lanes);
        exp_t e;
        int acc, idx;
        bit got;
        logic [31:0] word;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = lanes;
        acc = (cyc_cnt + 1 > next_free[k]) ? cyc_cnt + 1 : next_free[k];
        if (in_win_m(k, a)) begin
            idx = int'((longint'(a) - base_of(k)) / 4);
            if (w) begin
                word = mem_m[k][idx];
                for (int b = 0; b < 4; b++) if (lanes[b]) word[8*b +: 8] = d[8*b +: 8];
                mem_m[k][idx] = word;
            end else begin
                last_dat[k] = mem_m[k][idx];
            end
            e.is_err = 1'b0;
            e.cyc    = acc + ws_of(k);
        end else begin
            e.is_err = 1'b1;
            e.cyc    = acc;
        end
        e.dat = last_dat[k];
        q_push(k, e);
        next_free[k] = e.cyc + 2;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = ack[k] | err[k];
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d timeout: no ack/err for adr %h, expected one within 40 cycles", k, a);
        end
    endtask

    task automatic idle(input int k, input int n);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Launch a request without queueing an expectation; returns its accept edge
    task automatic launch_raw(input int k, input bit w, input logic [31:0] a,
                              input logic [31:0] d, output int acc);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = 4'hF;
        acc = (cyc_cnt + 1 > next_free[k]) ? cyc_cnt + 1 : next_free[k];
    endtask

    task automatic wait_cycle(input int target);
        for (int t = 0; t < 50 && cyc_cnt < target; t++) @(negedge clk);
    endtask

    function automatic logic [31:0] out_addr(input int k);
        logic [31:0] a;
        a = $urandom();
        for (int t = 0; t < 20 && in_win_m(k, a); t++) a = $urandom();
        return in_win_m(k, a) ? 32'hFFFF_FFFC : a;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc, n0, prev_ack, now_ack, op;
        logic [31:0] a;
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0; rst_n = '0;
        for (int k = 0; k < N; k++) begin
            last_dat[k] = '0; next_free[k] = 0; resp_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("dut%0d reset_ack", k), {31'b0, ack[k]}, 32'd0);
            check_eq($sformatf("dut%0d reset_err", k), {31'b0, err[k]}, 32'd0);
            check_eq($sformatf("dut%0d reset_dat", k), rdat[k], 32'd0);
        end
        rst_n = '1;
        @(negedge clk);

        // One wait state: write then read back
        do_req(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(2, 1'b0, 32'h10, 32'h0, 4'hF);
        check_eq("ws1 readback", rdat[2], 32'hDEADBEEF);
        idle(2, 1);

        // Byte-lane merge, then a sel=0 write that must not change anything
        do_req(2, 1'b1, 32'h20, 32'h11223344, 4'hF);
        do_req(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
        check_eq("sel merge", rdat[2], 32'h11BB33DD);
        do_req(2, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        do_req(2, 1'b0, 32'h20, 32'h0, 4'hF);
        check_eq("sel zero write", rdat[2], 32'h11BB33DD);
        idle(2, 2);

        // Window edges on the offset instance
        do_req(0, 1'b1, 32'h1FFC, 32'hCAFEF00D, 4'hF);
        do_req(0, 1'b0, 32'h1FFC, 32'h0, 4'hF);
        do_req(0, 1'b0, 32'h0FFC, 32'h0, 4'hF);
        check_eq("below window dat held", rdat[0], 32'hCAFEF00D);
        do_req(0, 1'b0, 32'h2000, 32'h0, 4'hF);
        do_req(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
        idle(0, 2);

        // Cycle dropped in the second wait cycle: no response, no write
        do_req(0, 1'b1, 32'h1000, 32'h01020304, 4'hF);
        idle(0, 1);
        n0 = resp_cnt[0];
        launch_raw(0, 1'b1, 32'h1000, 32'hFFFFFFFF, acc);
        wait_cycle(acc + 1);
        cyc[0] = 1'b0;
        next_free[0] = acc + 3;
        repeat (6) @(negedge clk);
        check_eq("abort no response", resp_cnt[0], n0);
        do_req(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        check_eq("abort word intact", rdat[0], 32'h01020304);
        idle(0, 1);

        // Reset in the middle of a waiting write
        do_req(0, 1'b1, 32'h1004, 32'h55AA0FF0, 4'hF);
        do_req(0, 1'b0, 32'h1004, 32'h0, 4'hF);
        idle(0, 1);
        launch_raw(0, 1'b1, 32'h1004, 32'hFFFF0000, acc);
        wait_cycle(acc + 1);
        #2 rst_n[0] = 1'b0;
        #1;
        check_eq("midwait reset ack", {31'b0, ack[0]}, 32'd0);
        check_eq("midwait reset err", {31'b0, err[0]}, 32'd0);
        check_eq("midwait reset dat", rdat[0], 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1; last_dat[0] = '0; next_free[0] = 0;
        do_req(0, 1'b0, 32'h1004, 32'h0, 4'hF);
        check_eq("post reset read", rdat[0], 32'h55AA0FF0);
        // Reset while ack is high must drop it at once
        #2 rst_n[0] = 1'b0;
        #1;
        check_eq("ack drops on reset", {31'b0, ack[0]}, 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1; last_dat[0] = '0; next_free[0] = 0;
        idle(0, 1);

        // Zero wait states: strobe held for back-to-back transfers
        for (int i = 0; i < 4; i++) do_req(1, 1'b1, 32'(i * 4), 32'hA0000000 + 32'(i), 4'hF);
        prev_ack = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b0, 32'(i * 4), 32'h0, 4'hF);
            now_ack = cyc_cnt;
            if (i > 0) check_eq($sformatf("b2b spacing %0d", i), now_ack - prev_ack, 32'd2);
            prev_ack = now_ack;
        end
        check_eq("b2b last data", rdat[1], 32'hA0000003);
        idle(1, 2);

        // Randomised traffic against the model
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 8; i++) do_req(k, 1'b1, 32'(base_of(k) + i * 4), $urandom(), 4'hF);
            idle(k, 1);
            for (int n = 0; n < 50; n++) begin
                op = $urandom_range(0, 9);
                if (op == 0) begin
                    cyc[k] = 1'($urandom_range(0, 1));
                    stb[k] = ~cyc[k];
                    adr[k] = 32'(base_of(k));
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    idle(k, 0);
                end else begin
                    a = (op == 1) ? out_addr(k)
                                  : 32'(base_of(k) + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
                    do_req(k, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 2));
                end
            end
            idle(k, 3);
        end

        repeat (10) @(negedge clk);
        for (int k = 0; k < N; k++) check_eq($sformatf("dut%0d pending", k), q_size(k), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
